// File: rtl/shift_arbiter_if.sv
// Handshake bundle for shift_arbiter: two request channels (word, shift amount
// and direction under valid/ready) and one result channel (word plus requester
// id under valid/ready).
//   master : the producer/consumer side (drives requests, accepts results)
//   slave  : the arbiter side (accepts requests, presents results)
interface shift_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_data;
    logic [AMT_W-1:0] req0_amt;
    logic             req0_dir;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_data;
    logic [AMT_W-1:0] req1_amt;
    logic             req1_dir;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_id;

    modport master (
        output req0_valid, req0_data, req0_amt, req0_dir,
        input  req0_ready,
        output req1_valid, req1_data, req1_amt, req1_dir,
        input  req1_ready,
        input  out_valid, out_data, out_id,
        output out_ready
    );

    modport slave (
        input  req0_valid, req0_data, req0_amt, req0_dir,
        output req0_ready,
        input  req1_valid, req1_data, req1_amt, req1_dir,
        output req1_ready,
        output out_valid, out_data, out_id,
        input  out_ready
    );
endinterface

// File: rtl/shift_arbiter.sv
// Two requesters share one rotating barrel shifter. A round-robin arbiter
// grants one request per accept cycle; the rotated word and the id of the
// winning requester are held in an output register with its own valid/ready
// handshake. A result is visible the cycle after its accept, and a drain and
// a new accept may happen in the same cycle, so throughput is one per cycle.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : shift_arbiter_if.slave (req0/req1 request channels, out channel)
module shift_arbiter #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    shift_arbiter_if.slave                            bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             id_q, id_d;

    logic             free;
    logic             gnt0, gnt1, accept;
    logic [WIDTH-1:0] sel_data;
    logic [AMT_W-1:0] sel_amt;
    logic             sel_dir;

    // Circular rotate built as log2(WIDTH) mux stages; stage k rotates by 2**k
    // when amount bit k is set, in the requested direction.
    function automatic logic [WIDTH-1:0] rotate(
        input logic [WIDTH-1:0] d,
        input logic [AMT_W-1:0] a,
        input logic             dir
    );
        logic [WIDTH-1:0] s;
        int               sh;
        s = d;
        for (int k = 0; k < AMT_W; k++) begin
            sh = 1 << k;
            if (a[k]) begin
                if (dir)
                    s = (s >> sh) | (s << (WIDTH - sh));
                else
                    s = (s << sh) | (s >> (WIDTH - sh));
            end
        end
        return s;
    endfunction

    // Slot is free when empty or when the held result leaves this cycle.
    assign free = (state_q == EMPTY) || bus.out_ready;

    // The pointer only matters on a tie; it names the requester that wins it.
    assign gnt0   = rst_n && free && bus.req0_valid && (!bus.req1_valid || !ptr_q);
    assign gnt1   = rst_n && free && bus.req1_valid && (!bus.req0_valid ||  ptr_q);
    assign accept = gnt0 || gnt1;

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    // One shared rotator: steer the winning request into it.
    assign sel_data = gnt1 ? bus.req1_data : bus.req0_data;
    assign sel_amt  = gnt1 ? bus.req1_amt  : bus.req0_amt;
    assign sel_dir  = gnt1 ? bus.req1_dir  : bus.req0_dir;

    // Control FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    // Control FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (!accept && bus.out_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Control FSM: outputs
    always_comb begin
        bus.out_valid = (state_q == FULL);
    end

    // Result register and round-robin pointer next values
    always_comb begin
        data_d = data_q;
        id_d   = id_q;
        ptr_d  = ptr_q;
        if (accept) begin
            data_d = rotate(sel_data, sel_amt, sel_dir);
            id_d   = gnt1;
            ptr_d  = !gnt1;   // the other requester wins the next tie
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            id_q   <= 1'b0;
            ptr_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            id_q   <= id_d;
            ptr_q  <= ptr_d;
        end
    end

    assign bus.out_data = data_q;
    assign bus.out_id   = id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed stimulus pushes hand-computed results
// into a scoreboard queue; a monitor pops and compares whenever a result is
// handed to the consumer (out_valid && out_ready).
module tb_shift_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shift_arbiter_if #(.WIDTH(4), .AMT_W(2)) bus ();

    shift_arbiter #(.WIDTH(4), .AMT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic       id;
        logic [3:0] data;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handed-over result must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%0h expected=none",
                         {bus.out_id, bus.out_data});
            end else begin
                e = q.pop_front();
                chk("sb_out", 32'({bus.out_id, bus.out_data}), 32'({e.id, e.data}));
            end
        end
    end

    // Issue one request on requester n; caller is at posedge+1. Returns at
    // posedge+1 just after the accept edge. waited = cycles spent before ready.
    task automatic send(input int n, input logic [3:0] d, input logic [1:0] a,
                        input logic dir, input logic [3:0] exp_d, output int waited);
        exp_t e;
        logic rdy;
        waited = 0;
        if (n == 0) begin
            bus.req0_data = d; bus.req0_amt = a; bus.req0_dir = dir; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_data = d; bus.req1_amt = a; bus.req1_dir = dir; bus.req1_valid = 1'b1;
        end
        e.id = (n != 0);
        e.data = exp_d;
        q.push_back(e);
        @(negedge clk);
        rdy = (n == 0) ? bus.req0_ready : bus.req1_ready;
        while (!rdy && waited < 20) begin
            @(negedge clk);
            waited++;
            rdy = (n == 0) ? bus.req0_ready : bus.req1_ready;
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=no_ready expected=ready req=%0d", n);
        end
        tick();
        if (n == 0) bus.req0_valid = 1'b0;
        else        bus.req1_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [3:0] tl[4];
    logic [3:0] tr[4];
    int         w;

    initial begin
        tl = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        tr = '{4'b1101, 4'b1110, 4'b0111, 4'b1011};
        bus.req0_valid = 0; bus.req0_data = 0; bus.req0_amt = 0; bus.req0_dir = 0;
        bus.req1_valid = 0; bus.req1_data = 0; bus.req1_amt = 0; bus.req1_dir = 0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;

        // Reset: ready must stay low even with requests pending
        repeat (2) @(posedge clk);
        #1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        @(negedge clk);
        chk("rst_ready0", 32'(bus.req0_ready), 0);
        chk("rst_ready1", 32'(bus.req1_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_out_id", 32'(bus.out_id), 0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_out_valid", 32'(bus.out_valid), 0);
        chk("idle_out_data", 32'(bus.out_data), 0);
        chk("idle_ready0", 32'(bus.req0_ready), 0);
        chk("idle_ready1", 32'(bus.req1_ready), 0);
        tick();

        // Single requester, ready in the same cycle
        send(0, 4'b1101, 2'b01, 1'b0, 4'b1011, w);
        chk("single_left_wait", 32'(w), 0);
        @(negedge clk);
        chk("single_left_valid", 32'(bus.out_valid), 1);
        tick();
        send(0, 4'b1101, 2'b01, 1'b1, 4'b1110, w);
        chk("single_right_wait", 32'(w), 0);

        // Full rotation table on requester 1
        for (int a = 0; a < 4; a++) send(1, 4'b1101, 2'(a), 1'b0, tl[a], w);
        for (int a = 0; a < 4; a++) send(1, 4'b1101, 2'(a), 1'b1, tr[a], w);
        @(negedge clk);
        tick();
        chk("table_drained", 32'(q.size()), 0);

        // Fresh reset so the tie sequence starts from requester 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Tie and fairness: grants 0,1,0,1 with no bubble
        bus.req0_data = 4'b0001; bus.req0_amt = 2'd1; bus.req0_dir = 1'b0;
        bus.req1_data = 4'b1000; bus.req1_amt = 2'd1; bus.req1_dir = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        q.push_back('{id: 1'b0, data: 4'b0010});
        q.push_back('{id: 1'b1, data: 4'b0100});
        q.push_back('{id: 1'b0, data: 4'b1100});
        q.push_back('{id: 1'b1, data: 4'b0011});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("tie_grant", 32'({bus.req1_ready, bus.req0_ready}),
                (k % 2 == 1) ? 32'h2 : 32'h1);
            if (k > 0) chk("tie_nobubble", 32'(bus.out_valid), 1);
            tick();
            case (k)
                0: begin bus.req0_data = 4'b0011; bus.req0_amt = 2'd2; bus.req0_dir = 1'b1; end
                1: begin bus.req1_data = 4'b0110; bus.req1_amt = 2'd3; bus.req1_dir = 1'b0; end
                2: bus.req0_valid = 1'b0;
                default: bus.req1_valid = 1'b0;
            endcase
        end

        // Back-pressure: last tie result (id 1, 0011) held for 3 cycles
        bus.out_ready = 1'b0;
        bus.req0_data = 4'b1001; bus.req0_amt = 2'd2; bus.req0_dir = 1'b0;
        bus.req1_data = 4'b0101; bus.req1_amt = 2'd1; bus.req1_dir = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready0", 32'(bus.req0_ready), 0);
            chk("bp_ready1", 32'(bus.req1_ready), 0);
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_data", 32'(bus.out_data), 32'(4'b0011));
            tick();
        end
        bus.out_ready = 1'b1;
        q.push_back('{id: 1'b0, data: 4'b0110});
        q.push_back('{id: 1'b1, data: 4'b1010});
        @(negedge clk);
        chk("bp_drain_accept0", 32'({bus.req1_ready, bus.req0_ready}), 32'h1);
        tick();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("bp_accept1", 32'({bus.req1_ready, bus.req0_ready}), 32'h2);
        tick();
        bus.req1_valid = 1'b0;

        // Reset mid-stall: leave pointer at requester 1, then reset
        send(0, 4'b0001, 2'd0, 1'b1, 4'b0001, w);
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("stall_valid", 32'(bus.out_valid), 1);
        tick();
        rst_n = 1'b0;
        tick();
        void'(q.pop_back());   // held result is discarded by reset
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("rst2_out_valid", 32'(bus.out_valid), 0);
        chk("rst2_out_data", 32'(bus.out_data), 0);
        chk("rst2_out_id", 32'(bus.out_id), 0);
        tick();
        bus.req0_data = 4'b1110; bus.req0_amt = 2'd0; bus.req0_dir = 1'b0;
        bus.req1_data = 4'b0111; bus.req1_amt = 2'd2; bus.req1_dir = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        q.push_back('{id: 1'b0, data: 4'b1110});
        q.push_back('{id: 1'b1, data: 4'b1101});
        @(negedge clk);
        chk("rst2_tie_grant", 32'({bus.req1_ready, bus.req0_ready}), 32'h1);
        tick();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("rst2_second_grant", 32'({bus.req1_ready, bus.req0_ready}), 32'h2);
        tick();
        bus.req1_valid = 1'b0;

        repeat (3) tick();
        chk("sb_empty", 32'(q.size()), 0);
        chk("final_idle", 32'(bus.out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one registered rotating barrel shifter between two independent requesters.
- Each requester presents a word, a shift amount and a direction under a valid/ready handshake.
- A round-robin arbiter picks one request per accept cycle, rotates the word, and holds the result in an output register with its own valid/ready handshake.
- Sits between upstream producers and a single downstream consumer.

Parameters:
- WIDTH, 4, data word width in bits; must be a power of two and ≥ 2.
- AMT_W, 2, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- req0_valid  input  1  requester 0 has a request.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req0_data  input  WIDTH  requester 0 word.
- req0_amt  input  AMT_W  requester 0 shift amount.
- req0_dir  input  1  requester 0 direction: 0 = rotate left, 1 = rotate right.
- req1_valid, req1_ready, req1_data, req1_amt, req1_dir: same as requester 0, for requester 1.
- out_valid  output  1  output register holds a result.
- out_ready  input  1  consumer takes the result.
- out_data  output  WIDTH  rotated word.
- out_id  output  1  index of the requester that produced out_data.

Behaviour:
- Reset (rst_n low at a clock edge):
  - out_valid = 0, out_data = 0, out_id = 0.
  - Priority pointer = requester 0.
  - req0_ready = req1_ready = 0 during the reset cycle.
  - Reset mid-transaction discards the held result and does not complete any in-progress handshake.
- Slot free:
  - free = !out_valid || out_ready (combinational).
  - Only while free and out of reset may a request be accepted.
- Arbitration (combinational, each cycle):
  - If free and exactly one reqN_valid, grant N.
  - If free and both valid, grant the requester the pointer names.
  - reqN_ready = 1 only for the granted requester; at most one ready high per cycle.
  - ready never depends on the requester's own valid toggling within a cycle beyond this rule.
- Accept (reqN_valid && reqN_ready at a clock edge):
  - out_data <= rot(reqN_data, reqN_amt, reqN_dir).
  - out_id <= N.
  - out_valid <= 1.
  - Pointer <= !N, so the other requester wins the next tie.
  - Pointer is unchanged on cycles with no accept.
- Latency: result visible on out_data/out_valid the cycle after accept.
  - Throughput is one transaction per cycle while out_ready stays high.
- Drain:
  - out_valid && out_ready with no accept in the same cycle gives out_valid <= 0; out_data and out_id hold their last values.
  - Simultaneous drain and accept: the new result replaces the old with out_valid staying 1, giving no bubble.
- Back-pressure:
  - out_valid && !out_ready gives free = 0, so both ready signals are 0.
  - out_data and out_id are stable until drained.
- Requester rules:
  - Once reqN_valid is asserted, it must stay high with stable data, amt and dir until accepted.
  - The block does not check this rule.
- Rotate function rot(d, a, dir):
  - Circular; no bits lost, no fill bits.
  - dir = 0: bit i of result = d[(i - a) mod WIDTH] (left).
  - dir = 1: bit i of result = d[(i + a) mod WIDTH] (right).
  - a = 0 passes d unchanged.
  - Left by a equals right by WIDTH - a.
- Implementation structure:
  - Two-state control FSM: EMPTY (out_valid = 0) and FULL (out_valid = 1).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on drain without accept.
  - FULL→FULL on drain with accept or on stall.
  - EMPTY→EMPTY with no valid.
  - The rotator is log2(WIDTH) mux stages feeding the output register.

Test Plan:
- Reset then idle: rst_n = 0 for 2 cycles, then 1, all valids 0. Required: out_valid = 0, out_data = 0000, both ready = 0.
- Single requester: req0 data = 1101, amt = 01, dir = 0, out_ready = 1. Required: req0_ready = 1 in the same cycle; next cycle out_valid = 1, out_data = 1011, out_id = 0. Repeat with dir = 1: out_data = 1110.
- Full rotation table: req1 data = 1101, amt 00..11, for each dir. Required: left → 1101, 1011, 0111, 1110; right → 1101, 1110, 0111, 1011; out_id = 1 each time.
- Tie and fairness: both valids held high for 4 accepts, out_ready = 1. Required: grant order 0, 1, 0, 1 after reset; one result per cycle with no bubble.
- Back-pressure: result pending with out_ready = 0 for 3 cycles while both valids are high. Required: both ready = 0 and out_data stable; on out_ready = 1 the pending result drains and the next grant is accepted in the same cycle.
- Reset mid-stall: out_valid = 1, out_ready = 0, then pulse rst_n low for one cycle. Required: out_valid = 0, out_data = 0000, pointer back to requester 0; the first tie after reset is granted to requester 0.
